// File: rtl/morse_blinker_pkg.sv
`default_nettype none
// morse_blinker_pkg: Morse symbol codes, per-symbol unit counts and FSM encoding.
// Rev 1.0
package morse_blinker_pkg;

  typedef enum logic [1:0] {
    SYM_DOT  = 2'b00,
    SYM_DASH = 2'b01,
    SYM_LGAP = 2'b10,
    SYM_WGAP = 2'b11
  } sym_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ON   = 2'b01,
    ST_OFF  = 2'b10
  } state_t;

  localparam int UNIT_W = 3;

  localparam logic [UNIT_W-1:0] DOT_UNITS      = 3'd1;
  localparam logic [UNIT_W-1:0] DASH_UNITS     = 3'd3;
  localparam logic [UNIT_W-1:0] ELEM_GAP_UNITS = 3'd1;
  localparam logic [UNIT_W-1:0] LGAP_UNITS     = 3'd2;
  localparam logic [UNIT_W-1:0] WGAP_UNITS     = 3'd6;

  typedef struct packed {
    state_t             st;
    logic [UNIT_W-1:0]  units;
  } sym_load_t;

  // First phase of a symbol: gaps go straight to OFF with their full length.
  function automatic sym_load_t sym_load(input logic [1:0] code);
    sym_load_t r;
    r.st    = ST_OFF;
    r.units = WGAP_UNITS;
    case (code)
      SYM_DOT: begin
        r.st    = ST_ON;
        r.units = DOT_UNITS;
      end
      SYM_DASH: begin
        r.st    = ST_ON;
        r.units = DASH_UNITS;
      end
      SYM_LGAP: begin
        r.st    = ST_OFF;
        r.units = LGAP_UNITS;
      end
      default: begin
        r.st    = ST_OFF;
        r.units = WGAP_UNITS;
      end
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/morse_blinker_unit_tick.sv
`default_nettype none
// morse_unit_tick: Morse time-unit prescaler; MORSE_SLOW_EN adds slow_i to double a unit.
// Rev 1.0
module morse_unit_tick #(
  parameter int UNIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
`ifdef MORSE_SLOW_EN
  input  logic slow_i,
`endif
  output logic tick_o
);

  localparam int CNT_W = $clog2(2 * UNIT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] TC_NORM = CNT_W'(UNIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] w_tc;

`ifdef MORSE_SLOW_EN
  localparam logic [CNT_W-1:0] TC_SLOW = CNT_W'(2 * UNIT_CYCLES - 1);

  logic slow_q;
  logic w_slow;

  // slow is taken live on the first cycle of a unit and held for the rest of it.
  assign w_slow = (cnt_q == '0) ? slow_i : slow_q;
  assign w_tc   = w_slow ? TC_SLOW : TC_NORM;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slow_q <= 1'b0;
    end else if (en_i) begin
      slow_q <= w_slow;
    end
  end
`else
  assign w_tc = TC_NORM;
`endif

  assign tick_o = en_i && !clear_i && (cnt_q == w_tc);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == w_tc) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/morse_blinker.sv
`default_nettype none
// morse_blinker: programmable Morse symbol-string player driving one LED output.
// Rev 1.0 -- define MORSE_SLOW_EN to add the slow_i unit-doubling input.
module morse_blinker
  import morse_blinker_pkg::*;
#(
  parameter int UNIT_CYCLES = 4,
  parameter int MSG_LEN     = 16,
  parameter int LEN_W       = $clog2(MSG_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 repeat_i,
  input  logic [2*MSG_LEN-1:0] msg_i,
  input  logic [LEN_W-1:0]     msg_len_i,
`ifdef MORSE_SLOW_EN
  input  logic                 slow_i,
`endif
  output logic                 out_o,
  output logic                 busy_o,
  output logic                 done_o
);

  state_t               state_q, state_d;
  logic [UNIT_W-1:0]    units_q, units_d;
  logic [LEN_W-1:0]     idx_q, idx_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [2*MSG_LEN-1:0] msg_q, msg_d;
  logic                 out_q, out_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic             w_tick;
  logic             w_clear;
  logic             w_done_evt;
  logic [LEN_W-1:0] w_len_clamped;
  logic [LEN_W-1:0] w_next_idx;
  logic             w_last;
  logic [1:0]       w_next_code;
  sym_load_t        w_first;
  sym_load_t        w_next;
  sym_load_t        w_wrap;

  assign w_len_clamped = (msg_len_i > LEN_W'(MSG_LEN)) ? LEN_W'(MSG_LEN) : msg_len_i;
  assign w_next_idx    = idx_q + LEN_W'(1);
  assign w_last        = (idx_q == len_q - LEN_W'(1));

  always_comb begin
    w_next_code = 2'b00;
    for (int i = 0; i < MSG_LEN; i++) begin
      if (w_next_idx == LEN_W'(i)) begin
        w_next_code = msg_q[2*i +: 2];
      end
    end
  end

  assign w_first = sym_load(msg_i[1:0]);
  assign w_next  = sym_load(w_next_code);
  assign w_wrap  = sym_load(msg_q[1:0]);

  morse_unit_tick #(
    .UNIT_CYCLES (UNIT_CYCLES)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .clear_i (w_clear),
    .en_i    (state_q != ST_IDLE),
`ifdef MORSE_SLOW_EN
    .slow_i  (slow_i),
`endif
    .tick_o  (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      units_q <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      msg_q   <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      units_q <= units_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      msg_q   <= msg_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    units_d    = units_q;
    idx_d      = idx_q;
    len_d      = len_q;
    msg_d      = msg_q;
    w_clear    = 1'b0;
    w_done_evt = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i && !stop_i) begin
          if (w_len_clamped != '0) begin
            msg_d   = msg_i;
            len_d   = w_len_clamped;
            idx_d   = '0;
            w_clear = 1'b1;
            state_d = w_first.st;
            units_d = w_first.units;
          end else begin
            w_done_evt = 1'b1;
          end
        end
      end
      ST_ON: begin
        if (w_tick) begin
          if (units_q == UNIT_W'(1)) begin
            state_d = ST_OFF;
            units_d = ELEM_GAP_UNITS;
          end else begin
            units_d = units_q - UNIT_W'(1);
          end
        end
      end
      ST_OFF: begin
        if (w_tick) begin
          if (units_q != UNIT_W'(1)) begin
            units_d = units_q - UNIT_W'(1);
          end else if (!w_last) begin
            idx_d   = w_next_idx;
            state_d = w_next.st;
            units_d = w_next.units;
          end else if (repeat_i) begin
            idx_d   = '0;
            state_d = w_wrap.st;
            units_d = w_wrap.units;
          end else begin
            state_d    = ST_IDLE;
            w_done_evt = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides everything, including a completion on the same cycle.
    if (stop_i) begin
      state_d    = ST_IDLE;
      w_done_evt = 1'b0;
    end
  end

  always_comb begin
    out_d  = (state_d == ST_ON);
    busy_d = (state_d != ST_IDLE);
    done_d = w_done_evt;
  end

  assign out_o  = out_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule
`default_nettype wire
